vga_sync_decoder: RTL and testbench

Receive-side companion to the 800x600@60 VGA timing generator. Takes the generator's sync and blanking outputs (or any source with the same VESA timing) and rebuilds the pixel position from them. It measures line and frame periods, checks them against the nominal timing and reports lock. Downstream capture and checker logic use it to confirm the timing source without access to its counters.

---
 rtl/vga_sync_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position from VGA sync/blank inputs,
// measures line and frame periods and reports lock to the nominal timing.
module vga_sync_decoder #(
   parameter int unsigned H_TOTAL      = 1056,
   parameter int unsigned V_TOTAL      = 628,
   parameter int unsigned H_ACTIVE     = 800,
   parameter int unsigned V_ACTIVE     = 600,
   parameter int unsigned H_SYNC_START = 840,
   parameter int unsigned V_SYNC_START = 601,
   parameter int unsigned LOCK_FRAMES  = 2
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        hblnk,
   input  logic        vblnk,
   output logic [10:0] hcount_rx,
   output logic [10:0] vcount_rx,
   output logic [10:0] h_meas,
   output logic [10:0] v_meas,
   output logic        locked,
   output logic        frame_start,
   output logic [7:0]  err_cnt
);

   localparam int unsigned CW = 11;
   localparam int unsigned GW = 4;
   localparam int unsigned EW = 8;

   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_TOT_W   = CW'(H_TOTAL);
   localparam logic [CW-1:0] V_TOT_W   = CW'(V_TOTAL);
   localparam logic [CW-1:0] H_ACT_W   = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_W   = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_LOAD    = CW'((H_SYNC_START + 1) % H_TOTAL);
   localparam logic [CW-1:0] V_LOAD    = CW'(V_SYNC_START);
   localparam logic [GW-1:0] GOOD_NEED = GW'(LOCK_FRAMES);
   localparam logic [EW-1:0] ERR_MAX   = {EW{1'b1}};

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [GW-1:0]   good;
   logic [GW-1:0]   good_next;
   logic [GW-1:0]   good_inc;
   logic            frame_err;
   logic            frame_err_next;
   logic [EW-1:0]   err_cnt_next;

   logic            hs_d;
   logic            vs_d;
   logic            hrise;
   logic            vrise;
   logic            h_wrap;
   logic            h_valid;
   logic [CW-1:0]   per_cnt;
   logic [CW-1:0]   per_plus1;
   logic [CW-1:0]   line_cnt;
   logic            h_err;
   logic            v_err;
   logic            b_err;
   logic            any_err;

   // Sync edge detection on the raw inputs against last cycle's level
   assign hrise  = hsync & ~hs_d;
   assign vrise  = vsync & ~vs_d;
   assign h_wrap = (hcount_rx == H_LAST);

   // Saturating line period including the current clock
   assign per_plus1 = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CW'(1);

   // Timing checks; only acted on outside SEARCH
   assign h_err   = hrise & h_valid & (per_plus1 != H_TOT_W);
   assign v_err   = vrise & (line_cnt != V_TOT_W);
   assign b_err   = (hblnk != (hcount_rx >= H_ACT_W)) |
                    (vblnk != (vcount_rx >= V_ACT_W));
   assign any_err = h_err | v_err | b_err;

   assign good_inc    = good + GW'(1);
   assign frame_start = locked && (hcount_rx == '0) && (vcount_rx == '0);

   // Previous-cycle sync levels for edge detection
   always_ff @(posedge pclk) begin
      if (rst) begin
         hs_d <= 1'b0;
         vs_d <= 1'b0;
      end else begin
         hs_d <= hsync;
         vs_d <= vsync;
      end
   end

   // Horizontal position: free-running, realigned on every hsync rise
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_rx <= '0;
      end else if (hrise) begin
         hcount_rx <= H_LOAD;
      end else if (h_wrap) begin
         hcount_rx <= '0;
      end else begin
         hcount_rx <= hcount_rx + CW'(1);
      end
   end

   // Vertical position: steps at line wrap, realigned on vsync rise
   always_ff @(posedge pclk) begin
      if (rst) begin
         vcount_rx <= '0;
      end else if (vrise) begin
         vcount_rx <= V_LOAD;
      end else if (h_wrap) begin
         if (vcount_rx == V_LAST) begin
            vcount_rx <= '0;
         end else begin
            vcount_rx <= vcount_rx + CW'(1);
         end
      end
   end

   // Line period measurement between hsync rises
   always_ff @(posedge pclk) begin
      if (rst) begin
         per_cnt <= '0;
         h_meas  <= '0;
         h_valid <= 1'b0;
      end else if (hrise) begin
         per_cnt <= '0;
         h_meas  <= per_plus1;
         h_valid <= 1'b1;
      end else if (per_cnt != CNT_MAX) begin
         per_cnt <= per_cnt + CW'(1);
      end
   end

   // Lines per frame; an hrise coincident with vrise opens the new frame
   always_ff @(posedge pclk) begin
      if (rst) begin
         line_cnt <= '0;
         v_meas   <= '0;
      end else if (vrise) begin
         line_cnt <= hrise ? CW'(1) : CW'(0);
         v_meas   <= line_cnt;
      end else if (hrise && (line_cnt != CNT_MAX)) begin
         line_cnt <= line_cnt + CW'(1);
      end
   end

   // Lock FSM state and registered status outputs
   always_ff @(posedge pclk) begin
      if (rst) begin
         state     <= SEARCH;
         good      <= '0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_next;
         good      <= good_next;
         frame_err <= frame_err_next;
         err_cnt   <= err_cnt_next;
         locked    <= (state_next == LOCKED);
      end
   end

   // Lock FSM next state: count clean frames, drop lock on any error
   always_comb begin
      state_next     = state;
      good_next      = good;
      frame_err_next = frame_err;
      err_cnt_next   = err_cnt;
      case (state)
         SEARCH: begin
            if (vrise) begin
               state_next     = ACQUIRE;
               good_next      = '0;
               frame_err_next = 1'b0;
            end
         end
         ACQUIRE: begin
            if (any_err) begin
               frame_err_next = 1'b1;
            end
            if (vrise) begin
               frame_err_next = 1'b0;
               if (frame_err || any_err) begin
                  good_next = '0;
               end else begin
                  good_next = good_inc;
                  if (good_inc >= GOOD_NEED) begin
                     state_next = LOCKED;
                  end
               end
            end
         end
         LOCKED: begin
            if (any_err) begin
               state_next     = ACQUIRE;
               good_next      = '0;
               frame_err_next = 1'b0;
               if (err_cnt != ERR_MAX) begin
                  err_cnt_next = err_cnt + EW'(1);
               end
            end
         end
         default: begin
            state_next     = SEARCH;
            good_next      = '0;
            frame_err_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives the decoder from a reduced-size VGA timing
// source (40x12 total) and checks lock, tracking and fault reactions.
module tb_vga_sync_decoder;

   localparam int H   = 40;
   localparam int V   = 12;
   localparam int HA  = 30;
   localparam int VA  = 8;
   localparam int HSS = 32;
   localparam int VSS = 9;
   localparam int HSW = 4;
   localparam int VSW = 2;
   localparam int LF  = 2;
   localparam int FRAME    = H * V;
   localparam int LOCK_CYC = VSS * H + LF * FRAME + 1;

   typedef enum int {F_HS, F_EXTRA, F_HB, F_RST} fault_e;

   typedef struct {
      fault_e kind;
      int     f_line;
      int     f_h;
      int     err_off;
      int     relock_off;
      int     exp_err;
      int     exp_hm;
      int     exp_vm;
   } vec_t;

   logic        pclk = 1'b0;
   logic        rst;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [10:0] hcount_rx;
   logic [10:0] vcount_rx;
   logic [10:0] h_meas;
   logic [10:0] v_meas;
   logic        locked;
   logic        frame_start;
   logic [7:0]  err_cnt;

   vga_sync_decoder #(
      .H_TOTAL      (H),
      .V_TOTAL      (V),
      .H_ACTIVE     (HA),
      .V_ACTIVE     (VA),
      .H_SYNC_START (HSS),
      .V_SYNC_START (VSS),
      .LOCK_FRAMES  (LF)
   ) dut (
      .pclk        (pclk),
      .rst         (rst),
      .hsync       (hsync),
      .vsync       (vsync),
      .hblnk       (hblnk),
      .vblnk       (vblnk),
      .hcount_rx   (hcount_rx),
      .vcount_rx   (vcount_rx),
      .h_meas      (h_meas),
      .v_meas      (v_meas),
      .locked      (locked),
      .frame_start (frame_start),
      .err_cnt     (err_cnt)
   );

   always #5 pclk = ~pclk;

   int   n_checks;
   int   n_fail;
   int   sh;
   int   sv;
   int   cyc;
   int   cyc0;
   int   w;
   int   kill_lo;
   int   kill_hi;
   int   hb_cyc;
   int   rst_cyc;
   int   dup_line;
   bit   dup_pending;
   bit   trk_pos;
   bit   ph2;
   int   trk_bad;
   int   lock_drop;
   int   fs_n;
   int   fs_last;
   int   fs_gap;
   int   watch_from;
   int   first_hi;
   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Present the source state for the current cycle
   task automatic drive();
      hsync = (sh >= HSS) && (sh < HSS + HSW) && !((cyc >= kill_lo) && (cyc < kill_hi));
      vsync = (sv >= VSS) && (sv < VSS + VSW);
      hblnk = (sh >= HA) || (cyc == hb_cyc);
      vblnk = (sv >= VA);
      rst   = (cyc == rst_cyc);
   endtask

   task automatic observe();
      if (trk_pos && ((hcount_rx !== 11'(sh)) || (vcount_rx !== 11'(sv)))) trk_bad++;
      if (ph2) begin
         if (locked !== 1'b1) lock_drop++;
         if (frame_start === 1'b1) begin
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last = cyc;
            fs_n++;
         end
      end
      if ((watch_from >= 0) && (first_hi < 0) && (cyc >= watch_from) && (locked === 1'b1))
         first_hi = cyc;
   endtask

   task automatic advance();
      @(posedge pclk);
      #1;
      cyc++;
      if (sh == H - 1) begin
         sh = 0;
         if (dup_pending && (sv == dup_line)) dup_pending = 1'b0;
         else sv = (sv == V - 1) ? 0 : sv + 1;
      end else begin
         sh++;
      end
   endtask

   task automatic step();
      drive();
      observe();
      advance();
   endtask

   initial begin
      vecs[0] = '{F_HS,    2, 0,  152, 1321, 1, 80, 12};
      vecs[1] = '{F_EXTRA, 8, 0,  400, 1361, 2, 40, 13};
      vecs[2] = '{F_HB,    2, 5,   85,  841, 3, 40, 12};
      vecs[3] = '{F_RST,   3, 10, 130, 1321, 0,  0,  0};

      n_checks = 0; n_fail = 0;
      kill_lo = -1; kill_hi = -1; hb_cyc = -1; rst_cyc = -1; dup_line = -1;
      dup_pending = 1'b0; trk_pos = 1'b0; ph2 = 1'b0;
      trk_bad = 0; lock_drop = 0; fs_n = 0; fs_last = -1; fs_gap = -1;
      watch_from = -1; first_hi = -1;

      // Reset with random inputs: every output held at zero
      rst = 1'b1;
      hsync = 1'($urandom); vsync = 1'($urandom);
      hblnk = 1'($urandom); vblnk = 1'($urandom);
      @(posedge pclk);
      #1;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("reset_out_%0d", i),
               64'({hcount_rx, vcount_rx, h_meas, v_meas, err_cnt, locked, frame_start}), 64'(0));
         hsync = 1'($urandom); vsync = 1'($urandom);
         hblnk = 1'($urandom); vblnk = 1'($urandom);
         @(posedge pclk);
         #1;
      end

      // Clean source from (0,0): lock time, then two frames of tracking
      cyc = 0; sh = 0; sv = 0;
      trk_pos = 1'b1; watch_from = 0; first_hi = -1;
      while (cyc < LOCK_CYC + 2 * FRAME) begin
         if (cyc == LOCK_CYC) ph2 = 1'b1;
         step();
      end
      trk_pos = 1'b0; ph2 = 1'b0; watch_from = -1;
      check("first_lock_cycle", 64'(first_hi), 64'(1321));
      check("track_mismatch_cycles", 64'(trk_bad), 64'(0));
      check("lock_drop_cycles", 64'(lock_drop), 64'(0));
      check("frame_start_count", 64'(fs_n), 64'(2));
      check("frame_start_gap", 64'(fs_gap), 64'(480));
      check("h_meas_clean", 64'(h_meas), 64'(40));
      check("v_meas_clean", 64'(v_meas), 64'(12));
      check("err_cnt_clean", 64'(err_cnt), 64'(0));

      // Fault table: inject at a frame start, check loss, then relock time
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (!((sh == 0) && (sv == 0)) && (w < 2 * FRAME)) begin
            step();
            w++;
         end
         cyc0 = cyc;
         check($sformatf("v%0d_pre_locked", k), 64'(locked), 64'(1));
         case (vecs[k].kind)
            F_HS: begin
               kill_lo = cyc0 + vecs[k].f_line * H;
               kill_hi = kill_lo + H;
            end
            F_EXTRA: begin
               dup_line    = vecs[k].f_line;
               dup_pending = 1'b1;
            end
            F_HB:  hb_cyc  = cyc0 + vecs[k].f_line * H + vecs[k].f_h;
            F_RST: rst_cyc = cyc0 + vecs[k].f_line * H + vecs[k].f_h;
            default: ;
         endcase
         while (cyc < cyc0 + vecs[k].err_off) step();
         drive();
         check($sformatf("v%0d_locked_at_err", k), 64'(locked), 64'(1));
         advance();
         drive();
         check($sformatf("v%0d_locked_after", k), 64'(locked), 64'(0));
         check($sformatf("v%0d_err_cnt", k), 64'(err_cnt), 64'(vecs[k].exp_err));
         check($sformatf("v%0d_h_meas", k), 64'(h_meas), 64'(vecs[k].exp_hm));
         check($sformatf("v%0d_v_meas", k), 64'(v_meas), 64'(vecs[k].exp_vm));
         check($sformatf("v%0d_hcount", k), 64'(hcount_rx),
               64'((vecs[k].kind == F_RST) ? 0 : sh));
         check($sformatf("v%0d_vcount", k), 64'(vcount_rx),
               64'((vecs[k].kind == F_RST) ? 0 : sv));
         advance();
         watch_from = cyc; first_hi = -1;
         while (cyc <= cyc0 + vecs[k].relock_off + 2) step();
         check($sformatf("v%0d_relock_cycle", k), 64'(first_hi),
               64'(cyc0 + vecs[k].relock_off));
         watch_from = -1;
         kill_lo = -1; kill_hi = -1; hb_cyc = -1; rst_cyc = -1;
         dup_pending = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
